agu_req_gen: RTL and testbench
==============================

# agu_req_gen

Request generator that sits directly downstream of the address generation unit (AGU). It accepts a job (base address, request count), clears the AGU, then steps it once per accepted request. Each AGU offset is turned into an absolute memory address (base + offset) and presented on a valid/ready request stream toward the memory port. Each request carries the AGU jump tag and a last flag.

## Interface
- BWADDR, 21, address width; matches AGU address width
- BWCNT, 16, request-count width
- NJUMPS, 5, AGU jump count; width of jump tag
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  job start pulse; accepted only in IDLE
- base_addr  in  BWADDR  job base address; sampled with start
- count  in  BWCNT  number of requests in the job; sampled with start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job completion
- agu_clr  out  1  AGU clear
- agu_step  out  1  AGU step
- agu_addr  in  BWADDR  AGU current offset
- agu_on_j  in  NJUMPS  AGU jump indicator; valid in cycles where agu_step=1
- req_valid  out  1  request valid
- req_ready  in  1  request accepted by consumer
- req_addr  out  BWADDR  absolute address
- req_jmp  out  NJUMPS  agu_on_j captured with this request
- req_last  out  1  final request of the job

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN.
- IDLE, start=1, count≠0: latch base and count into `remaining`, go to CLEAR.
- IDLE, start=1, count=0: pulse done next cycle, stay IDLE. No agu_clr, no requests.
- start outside IDLE is ignored.
- CLEAR: agu_clr=1 for exactly one cycle, then go to RUN.
- RUN: single-entry output register. A load happens when `remaining>0` and (`!req_valid || req_ready`). On a load:
  - agu_step=1, combinationally, in that cycle;
  - req_addr <= base + agu_addr, modulo 2^BWADDR (carry discarded, wrap-around permitted);
  - req_jmp <= agu_on_j;
  - req_last <= (remaining==1);
  - remaining decrements.
- RUN, no load in a cycle: agu_step=0, so the AGU never advances during a stall.
- RUN → DRAIN when the last entry is loaded.
- DRAIN: hold the last request until req_valid & req_ready, then pulse done and go to IDLE.
- Handshake rules:
  - Once req_valid=1, req_addr, req_jmp and req_last stay stable until accepted.
  - req_valid never drops without a handshake (except abort, see Configuration).
  - No request is duplicated or dropped.
- Reset: all outputs 0 (busy, done, agu_clr, agu_step, req_valid, req_addr, req_jmp, req_last); state IDLE; remaining 0.
  - Reset mid-job abandons the job silently; done is not pulsed.

## Timing
- start sampled at edge 0 → CLEAR in cycle 1 (agu_clr=1) → first agu_step in cycle 2 → req_valid=1 from cycle 3, address base+0.
- Throughput: one request per cycle while req_ready=1.
- done asserts in the cycle after the handshake of the req_last request. busy falls in that same cycle.
- Earliest new start: the cycle done is high, since the FSM is already in IDLE.
- agu_step and agu_clr are never high in the same cycle.

## Configuration
- Macro: AGU_REQ_GEN_ABORT_EN.
- Defined: extra port `abort  in  1`.
  - abort=1 in CLEAR, RUN or DRAIN: next cycle state=IDLE, req_valid=0, remaining=0, agu_step=0, done pulses once.
  - req_valid may drop without a handshake only in this case.
  - abort in IDLE has no effect.
  - abort has priority over a simultaneous handshake; that request counts as not delivered.
- Not defined: no abort port; a job runs to completion or reset.

## Test plan
- Basic job: AGU set with l4=3, j4=1, j3=10; base=0x100; count=6; req_ready=1 → addresses 0x100,0x101,0x102,0x10C,0x10D,0x10E on consecutive cycles from cycle 3; req_jmp=on_j of each step; req_last only on 0x10E; done one cycle after that handshake.
- Backpressure: same job with req_ready toggling 1,0,0,1… → each address held stable while stalled; agu_step=0 in stall cycles; exactly 6 handshakes in order; no duplicates.
- count=0: start → done=1 next cycle; agu_clr, agu_step, req_valid stay 0 throughout.
- Wrap: base=0x1FFFFF; offsets 0,1,2 → req_addr 0x1FFFFF, 0x000000, 0x000001.
- start pulsed during RUN is ignored and the job completes unchanged. rst_n=0 mid-RUN → all outputs 0 next cycle, no done; a new job then starts cleanly with agu_clr.
- With AGU_REQ_GEN_ABORT_EN: abort at 2nd stall cycle → req_valid=0 and done=1 next cycle, state IDLE; following job starts from base+0.

Source files
------------

// File: rtl/agu_req_gen_if.sv
// Request stream from agu_req_gen toward the memory port.
// master: the request generator (drives valid/payload); slave: the consumer (drives ready).
interface agu_req_gen_if #(
    parameter int BWADDR = 21,
    parameter int NJUMPS = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [BWADDR-1:0] req_addr;
    logic [NJUMPS-1:0] req_jmp;
    logic              req_last;

    modport master (
        output req_valid,
        output req_addr,
        output req_jmp,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_jmp,
        input  req_last,
        output req_ready
    );
endinterface

// File: rtl/agu_req_gen.sv
// agu_req_gen: accepts a job (base, count), clears the AGU, then steps it once per
// loaded request and emits base+offset on a valid/ready stream with jump tag and last flag.
// Optional feature: define AGU_REQ_GEN_ABORT_EN to add the i_abort input, which cancels
// a running job and pulses done.
module agu_req_gen #(
    parameter int BWADDR = 21,
    parameter int BWCNT  = 16,
    parameter int NJUMPS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef AGU_REQ_GEN_ABORT_EN
    input  logic              i_abort,
`endif
    input  logic              i_start,
    input  logic [BWADDR-1:0] i_base_addr,
    input  logic [BWCNT-1:0]  i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_agu_clr,
    output logic              o_agu_step,
    input  logic [BWADDR-1:0] i_agu_addr,
    input  logic [NJUMPS-1:0] i_agu_on_j,
    agu_req_gen_if.master     req_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [BWADDR-1:0] r_base;
    logic [BWCNT-1:0]  r_remaining;
    logic              r_req_valid;
    logic [BWADDR-1:0] r_req_addr;
    logic [NJUMPS-1:0] r_req_jmp;
    logic              r_req_last;
    logic              r_done;

    logic              w_abort;
    logic              w_handshake;
    logic              w_load;
    logic              w_load_last;
    logic [BWADDR-1:0] w_abs_addr;

`ifdef AGU_REQ_GEN_ABORT_EN
    assign w_abort = i_abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_handshake = r_req_valid && req_if.req_ready;

    // The output register refills when it is empty or being drained this cycle; an abort
    // suppresses the load so the AGU is not advanced for a request that will never leave.
    assign w_load      = (r_state == S_RUN) && (r_remaining != '0) &&
                         (!r_req_valid || req_if.req_ready) && !w_abort;
    assign w_load_last = w_load && (r_remaining == BWCNT'(1));

    // Carry out of the top bit is discarded, so addresses wrap modulo 2^BWADDR.
    assign w_abs_addr  = r_base + i_agu_addr;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values, independent of process ordering.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves the signal
        // unassigned and a latch cannot be inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start && (i_count != '0)) w_next_state = S_CLEAR;
            S_CLEAR: w_next_state = S_RUN;
            S_RUN:   if (w_load_last) w_next_state = S_DRAIN;
            S_DRAIN: if (w_handshake) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (w_abort) w_next_state = S_IDLE;
    end

    // Outputs decoded from the state; the AGU step is combinational with the load.
    always_comb begin
        o_busy     = (r_state != S_IDLE);
        o_agu_clr  = (r_state == S_CLEAR);
        o_agu_step = w_load;
    end

    // Job registers, output request register and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_remaining <= '0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_jmp   <= '0;
            r_req_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_count != '0) begin
                            r_base      <= i_base_addr;
                            r_remaining <= i_count;
                        end else begin
                            // Empty job: complete immediately without touching the AGU.
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_load) begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= w_abs_addr;
                        r_req_jmp   <= i_agu_on_j;
                        r_req_last  <= (r_remaining == BWCNT'(1));
                        r_remaining <= r_remaining - BWCNT'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_handshake) begin
                        r_req_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Abort wins over a simultaneous handshake: the held request is discarded.
            if (w_abort) begin
                r_req_valid <= 1'b0;
                r_remaining <= '0;
                r_done      <= 1'b1;
            end
        end
    end

    assign o_done           = r_done;
    assign req_if.req_valid = r_req_valid;
    assign req_if.req_addr  = r_req_addr;
    assign req_if.req_jmp   = r_req_jmp;
    assign req_if.req_last  = r_req_last;

endmodule

// File: tb/tb_agu_req_gen.sv
// Directed testbench for agu_req_gen. A small AGU stub replays a fixed offset sequence
// (l4=3, j4=1, j3=10 gives offsets 0,1,2,12,13,14) with distinct jump tags per step.
// Cycle numbering: the edge that samples start is edge 0; cycle N follows edge N-1.
module tb_agu_req_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [20:0] base_addr;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        agu_clr;
    logic        agu_step;
    logic [20:0] agu_addr;
    logic [4:0]  agu_on_j;
`ifdef AGU_REQ_GEN_ABORT_EN
    logic        abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] exp_addr [0:7];
    logic [4:0]  exp_jmp  [0:7];

    agu_req_gen_if #(.BWADDR(21), .NJUMPS(5)) req_if ();

    agu_req_gen #(.BWADDR(21), .BWCNT(16), .NJUMPS(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef AGU_REQ_GEN_ABORT_EN
        .i_abort     (abort),
`endif
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_count     (count),
        .o_busy      (busy),
        .o_done      (done),
        .o_agu_clr   (agu_clr),
        .o_agu_step  (agu_step),
        .i_agu_addr  (agu_addr),
        .i_agu_on_j  (agu_on_j),
        .req_if      (req_if)
    );

    always #5 clk = ~clk;

    // AGU stub: clear resets the step index, each step advances it.
    logic [20:0] off_tab [0:7] = '{21'd0, 21'd1, 21'd2, 21'd12, 21'd13, 21'd14, 21'd15, 21'd16};
    logic [4:0]  jmp_tab [0:7] = '{5'h01, 5'h02, 5'h08, 5'h03, 5'h04, 5'h1F, 5'h05, 5'h06};
    logic [2:0]  agu_idx = '0;

    always @(posedge clk) begin
        if (agu_clr)       agu_idx <= '0;
        else if (agu_step) agu_idx <= agu_idx + 3'd1;
    end

    assign agu_addr = off_tab[agu_idx];
    assign agu_on_j = jmp_tab[agu_idx];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Runs one job. rmode 0: ready always high; rmode 1: ready high only when cycle%3==0.
    // restart_cyc: cycle in which a stray start (other base/count) is pulsed, -1 for none.
    task automatic run_job(input string name, input logic [20:0] base, input logic [15:0] cnt,
                           input int rmode, input int n_exp, input int restart_cyc);
        int          hs, last_hs_cyc, done_cyc, first_v;
        int          clr_cnt, step_cnt, stall_step, unstable, overlap;
        logic        held, busy_at_done;
        logic [20:0] h_addr;
        logic [4:0]  h_jmp;
        logic        h_last;
        hs = 0; last_hs_cyc = 0; done_cyc = -1; first_v = -1;
        clr_cnt = 0; step_cnt = 0; stall_step = 0; unstable = 0; overlap = 0;
        held = 1'b0; busy_at_done = 1'b1; h_addr = '0; h_jmp = '0; h_last = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        count     = cnt;
        req_if.req_ready = (rmode == 0);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_cyc);
            if (start) begin
                base_addr = 21'h055;
                count     = 16'd2;
            end
            req_if.req_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            if (cyc == 1) check({name, ":busy_c1"}, busy, (cnt != 0));
            if (agu_clr) clr_cnt++;
            if (agu_step) step_cnt++;
            if (agu_clr && agu_step) overlap++;
            if (held && (!req_if.req_valid || req_if.req_addr !== h_addr ||
                         req_if.req_jmp !== h_jmp || req_if.req_last !== h_last)) unstable++;
            if (req_if.req_valid && !req_if.req_ready && agu_step) stall_step++;
            if (req_if.req_valid && first_v < 0) first_v = cyc;
            if (req_if.req_valid && req_if.req_ready) begin
                if (hs < n_exp) begin
                    check({name, ":addr"}, req_if.req_addr, exp_addr[hs]);
                    check({name, ":jmp"},  req_if.req_jmp,  exp_jmp[hs]);
                    check({name, ":last"}, req_if.req_last, (hs == n_exp - 1));
                end else begin
                    check({name, ":extra_hs"}, hs + 1, n_exp);
                end
                hs++;
                last_hs_cyc = cyc;
            end
            held   = req_if.req_valid && !req_if.req_ready;
            h_addr = req_if.req_addr;
            h_jmp  = req_if.req_jmp;
            h_last = req_if.req_last;
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
                break;
            end
        end
        start = 1'b0;
        check({name, ":timeout"},    (done_cyc < 0), 1'b0);
        check({name, ":handshakes"}, hs, n_exp);
        check({name, ":done_cycle"}, done_cyc, last_hs_cyc + 1);
        check({name, ":busy_done"},  busy_at_done, 1'b0);
        check({name, ":clr_count"},  clr_cnt, (cnt != 0));
        check({name, ":step_count"}, step_cnt, n_exp);
        check({name, ":clr_step"},   overlap, 0);
        check({name, ":stall_step"}, stall_step, 0);
        check({name, ":stable"},     unstable, 0);
        if (rmode == 0 && n_exp > 0) begin
            check({name, ":first_valid"}, first_v, 3);
            check({name, ":last_hs"},     last_hs_cyc, n_exp + 2);
        end
        @(negedge clk);
        #1;
        check({name, ":done_pulse"}, done, 1'b0);
    endtask

    task automatic load_basic_exp(input logic [20:0] base);
        for (int i = 0; i < 8; i++) begin
            exp_addr[i] = base + off_tab[i];
            exp_jmp[i]  = jmp_tab[i];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int done_hits;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        req_if.req_ready = 1'b0;
`ifdef AGU_REQ_GEN_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst:busy",  busy, 1'b0);
        check("rst:done",  done, 1'b0);
        check("rst:clr",   agu_clr, 1'b0);
        check("rst:step",  agu_step, 1'b0);
        check("rst:valid", req_if.req_valid, 1'b0);
        check("rst:addr",  req_if.req_addr, 21'h0);
        check("rst:jmp",   req_if.req_jmp, 5'h0);
        check("rst:last",  req_if.req_last, 1'b0);
        rst_n = 1'b1;

        // Basic job: 0x100,0x101,0x102,0x10C,0x10D,0x10E back to back from cycle 3.
        exp_addr = '{21'h100, 21'h101, 21'h102, 21'h10C, 21'h10D, 21'h10E, 21'h0, 21'h0};
        exp_jmp  = '{5'h01, 5'h02, 5'h08, 5'h03, 5'h04, 5'h1F, 5'h0, 5'h0};
        run_job("basic", 21'h100, 16'd6, 0, 6, -1);

        // Backpressure with ready pattern 1,0,0 repeating.
        run_job("bp", 21'h100, 16'd6, 1, 6, -1);

        // Empty job.
        run_job("cnt0", 21'h100, 16'd0, 0, 0, -1);

        // Address wrap at the top of the address space.
        exp_addr = '{21'h1FFFFF, 21'h000000, 21'h000001, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0};
        exp_jmp  = '{5'h01, 5'h02, 5'h08, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0};
        run_job("wrap", 21'h1FFFFF, 16'd3, 0, 3, -1);

        // Stray start during RUN must not disturb the job.
        load_basic_exp(21'h040);
        run_job("restart", 21'h040, 16'd6, 0, 6, 5);

        // Reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; base_addr = 21'h200; count = 16'd4; req_if.req_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("midrst:valid_before", req_if.req_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst:busy",  busy, 1'b0);
        check("midrst:done",  done, 1'b0);
        check("midrst:clr",   agu_clr, 1'b0);
        check("midrst:step",  agu_step, 1'b0);
        check("midrst:valid", req_if.req_valid, 1'b0);
        check("midrst:addr",  req_if.req_addr, 21'h0);
        check("midrst:jmp",   req_if.req_jmp, 5'h0);
        check("midrst:last",  req_if.req_last, 1'b0);
        rst_n = 1'b1;
        done_hits = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done) done_hits++;
        end
        check("midrst:no_done", done_hits, 0);
        load_basic_exp(21'h300);
        run_job("after_rst", 21'h300, 16'd5, 0, 5, -1);

`ifdef AGU_REQ_GEN_ABORT_EN
        // Abort in the second stall cycle (cycle 5) of a backpressured job.
        @(negedge clk);
        start = 1'b1; base_addr = 21'h100; count = 16'd6; req_if.req_ready = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            req_if.req_ready = (cyc % 3 == 0);
            if (cyc == 5) abort = 1'b1;
        end
        #1;
        check("abort:valid_held", req_if.req_valid, 1'b1);
        check("abort:step_c5",    agu_step, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        req_if.req_ready = 1'b1;
        #1;
        check("abort:valid", req_if.req_valid, 1'b0);
        check("abort:done",  done, 1'b1);
        check("abort:busy",  busy, 1'b0);
        check("abort:step",  agu_step, 1'b0);
        @(negedge clk);
        #1;
        check("abort:done_pulse", done, 1'b0);
        exp_addr = '{21'h100, 21'h101, 21'h102, 21'h10C, 21'h10D, 21'h10E, 21'h0, 21'h0};
        exp_jmp  = '{5'h01, 5'h02, 5'h08, 5'h03, 5'h04, 5'h1F, 5'h0, 5'h0};
        run_job("post_abort", 21'h100, 16'd6, 0, 6, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
